// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: NPORTS registered lookups per cycle,
// one feedback update per cycle, write-first bypass from update to lookup.
module btb_assoc #(
    parameter int SETS   = 8,
    parameter int WAYS   = 2,
    parameter int NPORTS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [0:NPORTS-1][0:31]  lk_pc,
    output logic [0:NPORTS-1]        lk_hit,
    output logic [0:NPORTS-1]        lk_taken,
    output logic [0:NPORTS-1][0:31]  lk_target,
    input  logic                     fb_en,
    input  logic [0:31]              fb_pc,
    input  logic                     fb_taken,
    input  logic [0:31]              fb_target
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

    logic             valid   [SETS][WAYS];
    logic [TAG_W-1:0] tags    [SETS][WAYS];
    logic [0:31]      targets [SETS][WAYS];
    logic [1:0]       ctrs    [SETS][WAYS];
    logic [WAY_W-1:0] rr      [SETS];

    logic [IDX_W-1:0] fb_idx;
    logic [TAG_W-1:0] fb_tag;
    logic             fb_hit;
    logic [WAY_W-1:0] fb_way;
    logic             free_found;
    logic [WAY_W-1:0] free_way;
    logic             wr_en;
    logic             rr_adv;
    logic [WAY_W-1:0] wr_way;
    logic [0:31]      new_target;
    logic [1:0]       new_ctr;

    always_comb begin
        fb_idx     = fb_pc[30-IDX_W:29];
        fb_tag     = fb_pc[0:29-IDX_W];
        fb_hit     = 1'b0;
        fb_way     = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid[fb_idx][w] && tags[fb_idx][w] == fb_tag) begin
                fb_hit = 1'b1;
                fb_way = WAY_W'(w);
            end
            if (!valid[fb_idx][w] && !free_found) begin
                free_found = 1'b1;
                free_way   = WAY_W'(w);
            end
        end
        wr_en  = fb_en && !flush && (fb_hit || fb_taken);
        rr_adv = wr_en && !fb_hit && !free_found;
        wr_way = fb_hit ? fb_way : (free_found ? free_way : rr[fb_idx]);
        new_target = (fb_hit && !fb_taken) ? targets[fb_idx][fb_way] : fb_target;
        new_ctr    = 2'b10;
        if (fb_hit) begin
            new_ctr = ctrs[fb_idx][fb_way];
            if (fb_taken && new_ctr != 2'b11)
                new_ctr = new_ctr + 2'b01;
            else if (!fb_taken && new_ctr != 2'b00)
                new_ctr = new_ctr - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                rr[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    ctrs[s][w]  <= 2'b00;
                end
            end
        end else if (flush) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                rr[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++)
                    valid[s][w] <= 1'b0;
            end
        end else if (wr_en) begin
            valid[fb_idx][wr_way] <= 1'b1;
            ctrs[fb_idx][wr_way]  <= new_ctr;
            if (rr_adv)
                rr[fb_idx] <= (rr[fb_idx] == LAST_WAY) ? '0 : rr[fb_idx] + 1'b1;
        end
    end

    // Tag/target storage carries no reset; validity alone gates their use.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            tags[fb_idx][wr_way]    <= fb_tag;
            targets[fb_idx][wr_way] <= new_target;
        end
    end

    logic [0:NPORTS-1]  p_hit;
    logic [0:NPORTS-1]  p_taken;
    logic [0:31]        p_target [NPORTS];
    logic [IDX_W-1:0]   l_idx;
    logic [TAG_W-1:0]   l_tag;
    logic               e_valid;
    logic [TAG_W-1:0]   e_tag;
    logic [0:31]        e_target;
    logic [1:0]         e_ctr;

    // Each way is viewed as it will be after this cycle's update (write-first).
    always_comb begin
        p_hit    = '0;
        p_taken  = '0;
        l_idx    = '0;
        l_tag    = '0;
        e_valid  = 1'b0;
        e_tag    = '0;
        e_target = '0;
        e_ctr    = '0;
        for (int unsigned p = 0; p < NPORTS; p++) begin
            p_target[p] = '0;
            l_idx = lk_pc[p][30-IDX_W:29];
            l_tag = lk_pc[p][0:29-IDX_W];
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (wr_en && fb_idx == l_idx && wr_way == WAY_W'(w)) begin
                    e_valid  = 1'b1;
                    e_tag    = fb_tag;
                    e_target = new_target;
                    e_ctr    = new_ctr;
                end else begin
                    e_valid  = valid[l_idx][w];
                    e_tag    = tags[l_idx][w];
                    e_target = targets[l_idx][w];
                    e_ctr    = ctrs[l_idx][w];
                end
                if (e_valid && e_tag == l_tag) begin
                    p_hit[p]    = 1'b1;
                    p_taken[p]  = e_ctr[1];
                    p_target[p] = e_target;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            lk_hit    <= '0;
            lk_taken  <= '0;
            lk_target <= '0;
        end else begin
            for (int unsigned p = 0; p < NPORTS; p++) begin
                lk_hit[p]    <= p_hit[p];
                lk_taken[p]  <= p_taken[p];
                lk_target[p] <= p_target[p];
            end
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc: directed scenarios followed by random
// traffic, compared against a word-address-keyed behavioural model.
module tb_btb_assoc;

    localparam int SETS   = 8;
    localparam int WAYS   = 2;
    localparam int NPORTS = 2;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    flush = 1'b0;
    logic [0:NPORTS-1][0:31] lk_pc = '0;
    logic [0:NPORTS-1]       lk_hit;
    logic [0:NPORTS-1]       lk_taken;
    logic [0:NPORTS-1][0:31] lk_target;
    logic                    fb_en = 1'b0;
    logic [0:31]             fb_pc = '0;
    logic                    fb_taken = 1'b0;
    logic [0:31]             fb_target = '0;

    btb_assoc #(.SETS(SETS), .WAYS(WAYS), .NPORTS(NPORTS)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken), .lk_target(lk_target),
        .fb_en(fb_en), .fb_pc(fb_pc), .fb_taken(fb_taken), .fb_target(fb_target)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: each entry is keyed by the full word address (pc >> 2).
    typedef struct {
        bit              v;
        int unsigned     key;
        logic [31:0]     tgt;
        int              ctr;
    } ent_t;

    ent_t        m    [SETS][WAYS];
    int unsigned m_rr [SETS];

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m[s][w].v = 0;
        end
    endfunction

    function automatic void model_update(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
        int unsigned key = pc >> 2;
        int unsigned s = key % SETS;
        int found = -1;
        int victim = -1;
        for (int w = 0; w < WAYS; w++)
            if (m[s][w].v && m[s][w].key == key) found = w;
        if (found >= 0) begin
            m[s][found].ctr = tk ? ((m[s][found].ctr < 3) ? m[s][found].ctr + 1 : 3)
                                 : ((m[s][found].ctr > 0) ? m[s][found].ctr - 1 : 0);
            if (tk) m[s][found].tgt = tgt;
        end else if (tk) begin
            for (int w = WAYS - 1; w >= 0; w--)
                if (!m[s][w].v) victim = w;
            if (victim < 0) begin
                victim = int'(m_rr[s]);
                m_rr[s] = (m_rr[s] + 1) % WAYS;
            end
            m[s][victim].v   = 1;
            m[s][victim].key = key;
            m[s][victim].tgt = tgt;
            m[s][victim].ctr = 2;
        end
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, output bit hit, output bit tk,
                                         output logic [31:0] tgt);
        int unsigned key = pc >> 2;
        int unsigned s = key % SETS;
        hit = 0; tk = 0; tgt = '0;
        for (int w = 0; w < WAYS; w++)
            if (m[s][w].v && m[s][w].key == key) begin
                hit = 1; tk = (m[s][w].ctr >= 2); tgt = m[s][w].tgt;
            end
    endfunction

    task automatic step(input bit rst, input bit fl, input bit fen, input logic [31:0] fpc,
                        input bit ftk, input logic [31:0] ftgt,
                        input logic [31:0] pc0, input logic [31:0] pc1);
        bit          e_hit [NPORTS];
        bit          e_tk  [NPORTS];
        logic [31:0] e_tgt [NPORTS];
        logic [31:0] pcs   [NPORTS];
        @(negedge clk);
        reset = rst; flush = fl; fb_en = fen; fb_pc = fpc; fb_taken = ftk; fb_target = ftgt;
        pcs[0] = pc0; pcs[1] = pc1;
        for (int p = 0; p < NPORTS; p++) lk_pc[p] = pcs[p];
        if (rst || fl) model_clear();
        else if (fen) model_update(fpc, ftk, ftgt);
        for (int p = 0; p < NPORTS; p++) begin
            if (rst || fl) begin
                e_hit[p] = 0; e_tk[p] = 0; e_tgt[p] = '0;
            end else
                model_lookup(pcs[p], e_hit[p], e_tk[p], e_tgt[p]);
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < NPORTS; p++) begin
            check($sformatf("hit%0d pc=%h", p, pcs[p]), 32'(lk_hit[p]), 32'(e_hit[p]));
            check($sformatf("taken%0d pc=%h", p, pcs[p]), 32'(lk_taken[p]), 32'(e_tk[p]));
            check($sformatf("target%0d pc=%h", p, pcs[p]), lk_target[p], e_tgt[p]);
        end
    endtask

    task automatic fb(input logic [31:0] fpc, input bit ftk, input logic [31:0] ftgt,
                      input logic [31:0] pc0, input logic [31:0] pc1);
        step(0, 0, 1, fpc, ftk, ftgt, pc0, pc1);
    endtask

    task automatic look(input logic [31:0] pc0, input logic [31:0] pc1);
        step(0, 0, 0, '0, 0, '0, pc0, pc1);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        pc = ($urandom_range(0, 5) << 5) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
        if ($urandom_range(0, 3) == 0) pc = pc | 32'h8000_0000;
        return pc;
    endfunction

    initial begin
        model_clear();
        step(1, 0, 0, '0, 0, '0, '0, '0);
        step(1, 0, 0, '0, 0, '0, 32'h1000, 32'h1000);

        // cold miss, allocate with same-cycle lookup, then plain hit
        look(32'h1000, 32'h1004);
        fb(32'h1000, 1, 32'h2000, 32'h1000, 32'h3000);
        look(32'h1000, 32'h1000);
        fb(32'h3000, 0, 32'h4000, 32'h3000, 32'h1000);
        look(32'h3000, 32'h1003);

        // counter hysteresis and saturation
        fb(32'h1000, 0, 32'h9999, 32'h1000, 32'h0);
        fb(32'h1000, 0, 32'h9999, 32'h1000, 32'h0);
        fb(32'h1000, 1, 32'h2400, 32'h1000, 32'h0);
        fb(32'h1000, 1, 32'h2800, 32'h1000, 32'h0);
        for (int i = 0; i < 4; i++) fb(32'h1000, 1, 32'h2800 + i, 32'h1000, 32'h1000);
        fb(32'h1000, 0, 32'h0, 32'h1000, 32'h0);

        // conflict eviction within set 0, then bypass against an eviction
        fb(32'h1020, 1, 32'h3020, 32'h1020, 32'h1000);
        fb(32'h1040, 1, 32'h3040, 32'h1000, 32'h1040);
        look(32'h1020, 32'h1040);
        fb(32'h1060, 1, 32'h3060, 32'h1020, 32'h1060);
        look(32'h1000, 32'h1040);
        fb(32'h1000, 1, 32'h2000, 32'h1000, 32'h1040);
        look(32'h1000, 32'h1060);

        // flush beats feedback; reset beats feedback
        step(0, 1, 1, 32'h5000, 1, 32'h6000, 32'h1000, 32'h1060);
        look(32'h5000, 32'h1000);
        look(32'h1060, 32'h1020);
        fb(32'h7000, 1, 32'h7100, 32'h7000, 32'h0);
        step(1, 0, 1, 32'h7020, 1, 32'h7200, 32'h7000, 32'h7020);
        look(32'h7000, 32'h7020);

        for (int i = 0; i < 3000; i++) begin
            bit rst = ($urandom_range(0, 299) == 0);
            bit fl  = ($urandom_range(0, 149) == 0);
            bit fen = ($urandom_range(0, 9) < 7);
            bit tk  = ($urandom_range(0, 9) < 6);
            logic [31:0] fpc = rand_pc();
            logic [31:0] p0  = ($urandom_range(0, 3) == 0) ? fpc : rand_pc();
            logic [31:0] p1  = ($urandom_range(0, 7) == 0) ? p0 : rand_pc();
            step(rst, fl, fen, fpc, tk, $urandom, p0, p1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
